// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: FSM encoding, CPOL/CPHA mode codes,
// and the edge-counter width helper.
package spi_pkg;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    SETUP   = 5'b00010,
    SHIFT   = 5'b00100,
    HOLD    = 5'b01000,
    RX_WAIT = 5'b10000
  } state_e;

  // Mode code is {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int edge_cnt_w(input int data_width);
    return $clog2(2 * data_width) + 1;
  endfunction

  function automatic logic sample_on_lead(input logic [1:0] mode);
    case (mode)
      MODE0, MODE2: return 1'b1;
      MODE1, MODE3: return 1'b0;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_master_mc_clk_gen.sv
// SCK generator: divider counter producing a tick every div+1 cycles, plus
// leading/trailing edge strobes and the registered SCK level.
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 edge_en,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 sck
);

  logic                 run;
  logic                 phase;
  logic [DIV_WIDTH-1:0] cnt;

  assign tick       = run && (cnt == div);
  assign lead_edge  = tick && edge_en && !phase;
  assign trail_edge = tick && edge_en && phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= 1'b0;
      phase <= 1'b0;
      cnt   <= '0;
      sck   <= 1'b0;
    end else if (start) begin
      // start also re-parks SCK at idle level and realigns the phase
      run   <= 1'b1;
      phase <= 1'b0;
      cnt   <= '0;
      sck   <= cpol;
    end else begin
      if (stop) run <= 1'b0;
      if (run) cnt <= tick ? '0 : cnt + 1'b1;
      if (lead_edge || trail_edge) begin
        phase <= ~phase;
        sck   <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: full-duplex MSB-first words, all four
// CPOL/CPHA modes, programmable SCK half-period, registered pin outputs.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 2,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       cpol_i,
  input  logic                                       cpha_i,
  input  logic [DIV_WIDTH-1:0]                       clk_div_i,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel_i,
  input  logic [DATA_WIDTH-1:0]                      tx_data_i,
  input  logic                                       tx_valid_i,
  output logic                                       tx_ready_o,
  output logic [DATA_WIDTH-1:0]                      rx_data_o,
  output logic                                       rx_valid_o,
  input  logic                                       rx_ready_i,
  output logic                                       busy_o,
  output logic                                       err_o,
  output logic                                       sck_o,
  output logic [NUM_CS-1:0]                          cs_n_o,
  output logic                                       mosi_o,
  input  logic                                       miso_i
);

  localparam int              ECW       = edge_cnt_w(DATA_WIDTH);
  localparam logic [ECW-1:0]  LAST_EDGE = ECW'(2 * DATA_WIDTH);

  state_e                state, state_nxt;
  logic                  cpol_q, cpha_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic [ECW-1:0]        edge_cnt;

  logic accept, bad_cs, go, all_edges;
  logic cg_start, cg_stop, edge_en, cg_cpol;
  logic tick, lead, trail, sample, shift, samp_lead;

  assign accept    = (state == IDLE) && tx_valid_i;
  assign bad_cs    = (32'(cs_sel_i) >= 32'(NUM_CS));
  assign go        = accept && !bad_cs;
  assign all_edges = (edge_cnt == LAST_EDGE);

  // After the final edge one SHIFT cycle restarts the divider so HOLD is a full h cycles
  assign cg_start = go || ((state == SHIFT) && all_edges);
  assign cg_stop  = (state == HOLD) && tick;
  assign edge_en  = ((state == SETUP) || (state == SHIFT)) && !all_edges;
  assign cg_cpol  = (state == IDLE) ? cpol_i : cpol_q;

  assign samp_lead = sample_on_lead({cpol_q, cpha_q});
  assign sample    = samp_lead ? lead : trail;
  // CPHA=0 shifts on trailing edges but has nothing left to drive on the last one
  assign shift     = samp_lead ? (trail && (edge_cnt != LAST_EDGE - 1'b1)) : lead;

  spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
    .clk        (clk_i),
    .rst        (rst_i),
    .start      (cg_start),
    .stop       (cg_stop),
    .edge_en    (edge_en),
    .cpol       (cg_cpol),
    .div        (div_q),
    .tick       (tick),
    .lead_edge  (lead),
    .trail_edge (trail),
    .sck        (sck_o)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go)         state_nxt = SETUP;
      SETUP:   if (lead)       state_nxt = SHIFT;
      SHIFT:   if (all_edges)  state_nxt = HOLD;
      HOLD:    if (tick)       state_nxt = RX_WAIT;
      RX_WAIT: if (rx_ready_i) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      edge_cnt   <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      err_o      <= 1'b0;
      cs_n_o     <= '1;
      mosi_o     <= 1'b0;
    end else begin
      state <= state_nxt;
      err_o <= accept && bad_cs;
      if (go) begin
        cpol_q   <= cpol_i;
        cpha_q   <= cpha_i;
        div_q    <= clk_div_i;
        edge_cnt <= '0;
        rx_sr    <= '0;
        cs_n_o   <= ~(NUM_CS'(1) << cs_sel_i);
        if (cpha_i) begin
          tx_sr <= tx_data_i;
        end else begin
          mosi_o <= tx_data_i[DATA_WIDTH-1];
          tx_sr  <= {tx_data_i[DATA_WIDTH-2:0], 1'b0};
        end
      end
      if (lead || trail) edge_cnt <= edge_cnt + 1'b1;
      if (sample) rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso_i};
      if (shift) begin
        mosi_o <= tx_sr[DATA_WIDTH-1];
        tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      end
      if ((state == HOLD) && tick) begin
        cs_n_o     <= '1;
        rx_data_o  <= rx_sr;
        rx_valid_o <= 1'b1;
      end
      if ((state == RX_WAIT) && rx_ready_i) rx_valid_o <= 1'b0;
    end
  end

  assign tx_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_spi_master_mc.sv
// Randomised bench for spi_master_mc (8-bit words, 3 chip selects) with a
// behavioural slave and edge-level expectations derived from SPI mode rules.
module tb_spi_master_mc;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       cpol_i, cpha_i;
  logic [7:0] clk_div_i;
  logic [1:0] cs_sel_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       busy_o, err_o, sck_o, mosi_o, miso;
  logic [2:0] cs_n_o;

  logic loop, slave_bit;
  int   n_chk = 0;
  int   n_err = 0;

  assign miso = loop ? mosi_o : slave_bit;

  always #5 clk = ~clk;

  spi_master_mc #(.DATA_WIDTH(8), .NUM_CS(3), .DIV_WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .clk_div_i  (clk_div_i),
    .cs_sel_i   (cs_sel_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .sck_o      (sck_o),
    .cs_n_o     (cs_n_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_sck", sck_o, 0);
    chk("rst_cs", cs_n_o, 3'b111);
    chk("rst_mosi", mosi_o, 0);
  endtask

  // One full transfer; edges are expected at cycle 1+k*h after accept,
  // odd edges are leading, sample edges are leading iff cpha=0.
  task automatic xfer(input logic pol, input logic pha, input int div, input int cs,
                      input logic [7:0] tx, input logic [7:0] sw, input logic lb,
                      input int hold);
    int h, cyc, edges, bad, sidx, lat;
    logic [7:0] mseq, exp_rx;
    logic [2:0] exp_cs;
    logic prev_sck, done;
    h      = div + 1;
    exp_rx = lb ? tx : sw;
    exp_cs = ~(3'b001 << cs);
    cpol_i = pol; cpha_i = pha; clk_div_i = 8'(div); cs_sel_i = 2'(cs);
    tx_data_i = tx; tx_valid_i = 1'b1; rx_ready_i = (hold == 0); loop = lb;
    sidx = pha ? 7 : 6;
    slave_bit = pha ? 1'b0 : sw[7];
    @(negedge clk);
    tx_valid_i = 1'b0;
    cpol_i = 1'($urandom); cpha_i = 1'($urandom); clk_div_i = 8'($urandom);
    cs_sel_i = 2'($urandom); tx_data_i = 8'($urandom);
    cyc = 1; edges = 0; bad = 0; mseq = '0; prev_sck = pol; done = 1'b0; lat = 0;
    chk("cs_select", cs_n_o, exp_cs);
    chk("sck_idle", sck_o, pol);
    if (!pha) chk("mosi_first", mosi_o, tx[7]);
    while (!done && cyc < 400) begin
      if (rx_valid_o) begin
        done = 1'b1;
        lat  = cyc;
      end else begin
        if (sck_o != prev_sck) begin
          edges++;
          prev_sck = sck_o;
          if (cyc != 1 + edges * h) bad++;
          if (sck_o != ((edges % 2 == 1) ? ~pol : pol)) bad++;
          if ((edges % 2 == 1) != pha) mseq = {mseq[6:0], mosi_o};
          else if (sidx >= 0) begin
            slave_bit = sw[sidx];
            sidx--;
          end
        end
        if (cs_n_o != exp_cs) bad++;
        @(negedge clk);
        cyc++;
      end
    end
    chk("rx_valid_seen", done, 1);
    chk("edge_count", edges, 16);
    chk("edge_timing", bad, 0);
    chk("mosi_bits", mseq, tx);
    chk("rx_data", rx_data_o, exp_rx);
    chk("cs_release", cs_n_o, 3'b111);
    chk("sck_park", sck_o, pol);
    if (h == 1) chk("latency", lat, 19);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rx_valid_o !== 1'b1 || rx_data_o !== exp_rx || tx_ready_o !== 1'b0 ||
          cs_n_o !== 3'b111) bad++;
    end
    if (hold > 0) chk("rx_hold", bad, 0);
    rx_ready_i = 1'b1;
    @(negedge clk);
    chk("rx_clear", rx_valid_o, 0);
    chk("back_idle", tx_ready_o, 1);
  endtask

  initial begin
    int edges, cnt, gap, ph, nrx;
    logic prev;
    rst_i = 1'b1; cpol_i = 0; cpha_i = 0; clk_div_i = 0; cs_sel_i = 0;
    tx_data_i = 0; tx_valid_i = 0; rx_ready_i = 1; loop = 0; slave_bit = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_ready", tx_ready_o, 1);

    // Mode 0, h=1, fixed slave response
    xfer(0, 0, 0, 0, 8'hA5, 8'h3C, 0, 0);
    // Modes 1..3, h=4, loopback; mode 2 on chip select 1
    xfer(0, 1, 3, 0, 8'h81, 8'h00, 1, 0);
    xfer(1, 0, 3, 1, 8'h81, 8'h00, 1, 0);
    xfer(1, 1, 3, 2, 8'h81, 8'h00, 1, 0);
    // Consumer stalls 10 cycles
    xfer(0, 0, 1, 1, 8'h5C, 8'hE7, 0, 10);

    // Out-of-range chip select is dropped with an error pulse
    cs_sel_i = 2'd3; tx_data_i = 8'h77; tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    chk("err_pulse", err_o, 1);
    chk("err_ready", tx_ready_o, 1);
    chk("err_cs", cs_n_o, 3'b111);
    @(negedge clk);
    chk("err_clear", err_o, 0);
    chk("err_no_busy", busy_o, 0);

    // Reset in the middle of the shift phase
    cpol_i = 0; cpha_i = 0; clk_div_i = 1; cs_sel_i = 0; tx_data_i = 8'hC3;
    loop = 1; rx_ready_i = 0; tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    edges = 0; cnt = 0; prev = 1'b0;
    while (edges < 5 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (sck_o != prev) begin
        edges++;
        prev = sck_o;
      end
    end
    chk("rst_reach_edge5", edges, 5);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk_reset_vals();
    xfer(0, 0, 0, 2, 8'h3E, 8'h00, 1, 0);

    // Randomised transfers
    for (int i = 0; i < 10; i++)
      xfer(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
           8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Back-to-back with tx_valid held high
    cpol_i = 0; cpha_i = 0; clk_div_i = 0; cs_sel_i = 0; tx_data_i = 8'h5A;
    loop = 1; rx_ready_i = 1; tx_valid_i = 1'b1;
    gap = 0; ph = 0; nrx = 0;
    for (int c = 0; c < 200 && nrx < 2; c++) begin
      @(negedge clk);
      if (rx_valid_o) begin
        nrx++;
        chk("b2b_rx", rx_data_o, 8'h5A);
      end
      if (ph == 0 && cs_n_o != 3'b111) ph = 1;
      else if (ph == 1 && cs_n_o == 3'b111) begin
        ph  = 2;
        gap = 1;
      end else if (ph == 2) begin
        if (cs_n_o == 3'b111) gap++;
        else ph = 3;
      end
    end
    tx_valid_i = 1'b0;
    chk("b2b_words", nrx, 2);
    chk("b2b_cs_gap", (gap >= 1 && gap <= 2), 1);
    repeat (3) @(negedge clk);
    chk("final_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
